// File: rtl/ifm_pkg.sv
// Shared IFM-path definitions: skew/drain FSM encoding and lane slicing helper.
// Also used by the IFM address controller and the OFM side.
package ifm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } ifm_state_e;

    localparam int IFM_SIZE_W = 5;

    function automatic int lane_lsb(input int lane, input int data_width);
        return lane * data_width;
    endfunction

endpackage

// File: rtl/ifm_skew_buffer_if.sv
// Bus between the IFM address controller / RAM (master) and the skew buffer (slave).
interface ifm_skew_buffer_if #(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int DATA_WIDTH    = 16
);
    import ifm_pkg::*;

    logic                                read_en;
    logic [IFM_SIZE_W-1:0]               read_ifm_size;
    logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] ifm_rdata;
    logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] ifm_out;
    logic [SYSTOLIC_SIZE-1:0]            ifm_valid;
    logic                                busy;
    logic                                drain_done;

    modport master (
        output read_en, read_ifm_size, ifm_rdata,
        input  ifm_out, ifm_valid, busy, drain_done
    );

    modport slave (
        input  read_en, read_ifm_size, ifm_rdata,
        output ifm_out, ifm_valid, busy, drain_done
    );

endinterface

// File: rtl/skew_delay_line.sv
// Resettable DEPTH-stage shift register carrying one lane's {valid, data}.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
        end else begin
            stage[0] <= d;
            for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/ifm_skew_buffer.sv
// IFM skew buffer: captures RAM row words, masks unused lanes, skews lane i by i cycles.
// Optional macro IFM_LANE_MASK_EN enables per-read lane masking by read_ifm_size.
module ifm_skew_buffer
    import ifm_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int RAM_LATENCY   = 1
) (
    input logic              clk,
    input logic              rst_n,
    ifm_skew_buffer_if.slave bus
);

    localparam int CNT_W = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1;

    logic [RAM_LATENCY-1:0]          vld_pipe;
    logic                            rd_vld;
    logic [SYSTOLIC_SIZE-1:0]        lane_vld;
    logic [SYSTOLIC_SIZE-1:0]        s0_vld;
    logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] s0_data;
    logic [DATA_WIDTH:0]             lane_q [SYSTOLIC_SIZE];

    ifm_state_e       state, state_n;
    logic [CNT_W-1:0] drain_cnt, drain_cnt_n;
    logic             done_q, done_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= bus.read_en;
            for (int k = 1; k < RAM_LATENCY; k++) vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    assign rd_vld = vld_pipe[RAM_LATENCY-1];

`ifdef IFM_LANE_MASK_EN
    logic [IFM_SIZE_W-1:0] size_pipe [RAM_LATENCY];
    logic [IFM_SIZE_W-1:0] rd_size;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < RAM_LATENCY; k++) size_pipe[k] <= '0;
        end else begin
            size_pipe[0] <= bus.read_ifm_size;
            for (int k = 1; k < RAM_LATENCY; k++) size_pipe[k] <= size_pipe[k-1];
        end
    end

    assign rd_size = size_pipe[RAM_LATENCY-1];

    // Lane indices never exceed SYSTOLIC_SIZE-1, so sizes above it clamp naturally.
    always_comb begin
        lane_vld = '0;
        for (int i = 0; i < SYSTOLIC_SIZE; i++)
            lane_vld[i] = rd_vld && (32'(rd_size) > 32'(i));
    end
`else
    logic unused_size;
    assign unused_size = ^bus.read_ifm_size;

    always_comb begin
        lane_vld = '0;
        for (int i = 0; i < SYSTOLIC_SIZE; i++) lane_vld[i] = rd_vld;
    end
`endif

    // Invalid lanes are loaded as zero so nothing stale ever reaches the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_vld  <= '0;
            s0_data <= '0;
        end else begin
            for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
                s0_vld[i] <= lane_vld[i];
                s0_data[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] <=
                    lane_vld[i] ? bus.ifm_rdata[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] : '0;
            end
        end
    end

    for (genvar g = 0; g < SYSTOLIC_SIZE; g++) begin : g_lane
        if (g == 0) begin : g_direct
            assign lane_q[g] = {s0_vld[g], s0_data[g*DATA_WIDTH +: DATA_WIDTH]};
        end else begin : g_skew
            skew_delay_line #(
                .DEPTH (g),
                .WIDTH (DATA_WIDTH + 1)
            ) u_skew (
                .clk   (clk),
                .rst_n (rst_n),
                .d     ({s0_vld[g], s0_data[g*DATA_WIDTH +: DATA_WIDTH]}),
                .q     (lane_q[g])
            );
        end
    end

    always_comb begin
        bus.ifm_valid = '0;
        bus.ifm_out   = '0;
        for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
            bus.ifm_valid[i] = lane_q[i][DATA_WIDTH];
            bus.ifm_out[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = lane_q[i][DATA_WIDTH-1:0];
        end
    end

    // The FSM advances on the capture strobe so its state lines up with stage 0 on
    // ifm_out; drain_cnt counts lanes of the newest sample still inside the skew.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            drain_cnt <= '0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            drain_cnt <= drain_cnt_n;
            done_q    <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        drain_cnt_n = drain_cnt;
        done_n      = 1'b0;

        if (rd_vld)
            drain_cnt_n = CNT_W'(SYSTOLIC_SIZE - 1);
        else if (drain_cnt != '0)
            drain_cnt_n = drain_cnt - CNT_W'(1);

        case (state)
            IDLE: begin
                if (rd_vld) state_n = STREAM;
            end
            STREAM: begin
                if (!rd_vld) begin
                    if (drain_cnt_n == '0) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (rd_vld) begin
                    state_n = STREAM;
                end else if (drain_cnt_n == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.busy       = (state != IDLE);
    assign bus.drain_done = done_q;

endmodule
